// File: rtl/fcs_collector_if.sv
// Bundles the serial FCS input stream and the parallel word output
// handshake of the FCS collector into one connection.
interface fcs_collector_if #(
   parameter int REM_WIDTH = 16
);
   logic                 Ser_In;
   logic                 Ser_Valid;
   logic                 Ser_Done;
   logic [REM_WIDTH-1:0] FCS_Word;
   logic                 Word_Valid;
   logic                 Word_Ready;
   logic                 Len_Err;
   logic                 Overrun;
   logic                 Busy;

   // Producer/consumer side: drives the serial burst and the ready signal
   modport master (
      output Ser_In, Ser_Valid, Ser_Done, Word_Ready,
      input  FCS_Word, Word_Valid, Len_Err, Overrun, Busy
   );

   // Collector side
   modport slave (
      input  Ser_In, Ser_Valid, Ser_Done, Word_Ready,
      output FCS_Word, Word_Valid, Len_Err, Overrun, Busy
   );
endinterface

// File: rtl/fcs_collector.sv
// FCS collector: deserialises an MSB-first FCS bit burst into a parallel
// word, checks the burst length, and buffers completed words in a small
// FIFO with a valid/ready output handshake.
module fcs_collector #(
   parameter int REM_WIDTH  = 16,
   parameter int FIFO_DEPTH = 2
) (
   input logic            CLK,
   input logic            RST,
   fcs_collector_if.slave bus
);
   localparam int CW = $clog2(REM_WIDTH + 1);
   localparam int IW = (REM_WIDTH > 1) ? $clog2(REM_WIDTH) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_COUNT = CW'(REM_WIDTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [IW-1:0] TOP_BIT    = IW'(REM_WIDTH - 1);
   localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        bitCount_q, bitCount_d, countNext;
   logic [REM_WIDTH-1:0] shiftReg_q, shiftReg_d;
   logic [IW-1:0]        bitIdx;
   logic                 wordDone, lenErrSet;
   logic                 lenErr_q, overrun_q;

   logic [REM_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]          wrPtr_q, rdPtr_q;
   logic                 fifoEmpty, fifoFull, doPush, doPop;

   // Burst FSM: places each valid bit, tracks length, decides complete/error
   always_comb begin
      state_d    = state_q;
      bitCount_d = bitCount_q;
      shiftReg_d = shiftReg_q;
      countNext  = bitCount_q;
      wordDone   = 1'b0;
      lenErrSet  = 1'b0;
      bitIdx     = TOP_BIT - bitCount_q[IW-1:0];
      case (state_q)
         IDLE, SHIFT: begin
            if (bus.Ser_Valid) begin
               if (state_q == IDLE) begin
                  shiftReg_d                = '0;
                  shiftReg_d[REM_WIDTH-1]   = bus.Ser_In;
                  countNext                 = COUNT_ONE;
               end else begin
                  shiftReg_d[bitIdx] = bus.Ser_In;
                  countNext          = bitCount_q + COUNT_ONE;
               end
            end
            if (countNext == FULL_COUNT) begin
               if (bus.Ser_Done) begin
                  wordDone   = 1'b1;
                  state_d    = IDLE;
                  bitCount_d = '0;
               end else begin
                  state_d    = WAIT_DONE;
                  bitCount_d = countNext;
               end
            end else if (bus.Ser_Done) begin
               lenErrSet  = 1'b1;
               state_d    = IDLE;
               bitCount_d = '0;
            end else begin
               bitCount_d = countNext;
               if (bus.Ser_Valid) begin
                  state_d = SHIFT;
               end
            end
         end
         WAIT_DONE: begin
            if (bus.Ser_Valid) begin
               lenErrSet  = 1'b1;
               state_d    = IDLE;
               bitCount_d = '0;
            end else if (bus.Ser_Done) begin
               wordDone   = 1'b1;
               state_d    = IDLE;
               bitCount_d = '0;
            end
         end
         default: begin
            state_d    = IDLE;
            bitCount_d = '0;
         end
      endcase
   end

   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign doPop     = !fifoEmpty && bus.Word_Ready;
   assign doPush    = wordDone && (!fifoFull || doPop);

   // Collector state, FIFO pointers and the one-cycle status pulses
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         bitCount_q <= '0;
         shiftReg_q <= '0;
         lenErr_q   <= 1'b0;
         overrun_q  <= 1'b0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
      end else begin
         state_q    <= state_d;
         bitCount_q <= bitCount_d;
         shiftReg_q <= shiftReg_d;
         lenErr_q   <= lenErrSet;
         overrun_q  <= wordDone && fifoFull && !doPop;
         if (doPush) begin
            wrPtr_q <= wrPtr_q + PTR_ONE;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
      end
   end

   // FIFO storage; contents are only visible through the pointers
   always_ff @(posedge CLK) begin
      if (doPush) begin
         mem_q[wrPtr_q[AW-1:0]] <= shiftReg_d;
      end
   end

   assign bus.FCS_Word   = fifoEmpty ? '0 : mem_q[rdPtr_q[AW-1:0]];
   assign bus.Word_Valid = !fifoEmpty;
   assign bus.Len_Err    = lenErr_q;
   assign bus.Overrun    = overrun_q;
   assign bus.Busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fcs_collector.sv
// Directed testbench for the FCS collector.
module tb_fcs_collector;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   testCount = 0;
   int   failCount = 0;
   int   busyLow;

   fcs_collector_if #(.REM_WIDTH(16)) bus ();

   fcs_collector #(
      .REM_WIDTH (16),
      .FIFO_DEPTH(2)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Compares one observed value with its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of serial input and returns just after the edge
   task automatic applyStimulus(input logic valid, input logic serBit, input logic done);
      bus.Ser_Valid = valid;
      bus.Ser_In    = serBit;
      bus.Ser_Done  = done;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
      end
   endtask

   // Sends nBits MSB first (bits past 16 are zero), optional done on last bit
   task automatic sendBurst(input logic [15:0] word, input int nBits, input bit doneWithLast);
      for (int i = 0; i < nBits; i++) begin
         applyStimulus(1'b1, (i < 16) ? word[15-i] : 1'b0,
                       doneWithLast && (i == nBits - 1));
      end
   endtask

   initial begin
      logic [15:0] gapWord;
      gapWord        = 16'hC3A5;
      bus.Ser_Valid  = 1'b0;
      bus.Ser_In     = 1'b0;
      bus.Ser_Done   = 1'b0;
      bus.Word_Ready = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_valid",   {31'd0, bus.Word_Valid}, 32'd0);
      checkOutput("rst_word",    {16'd0, bus.FCS_Word},   32'd0);
      checkOutput("rst_busy",    {31'd0, bus.Busy},       32'd0);
      checkOutput("rst_lenerr",  {31'd0, bus.Len_Err},    32'd0);
      checkOutput("rst_overrun", {31'd0, bus.Overrun},    32'd0);
      rst = 1'b0;

      // Basic burst, done with last bit, consumer always ready
      bus.Word_Ready = 1'b1;
      sendBurst(16'h1D0F, 16, 1'b1);
      checkOutput("basic_valid",  {31'd0, bus.Word_Valid}, 32'd1);
      checkOutput("basic_word",   {16'd0, bus.FCS_Word},   32'h1D0F);
      checkOutput("basic_busy",   {31'd0, bus.Busy},       32'd0);
      checkOutput("basic_lenerr", {31'd0, bus.Len_Err},    32'd0);
      idleCycles(1);
      checkOutput("basic_valid_1cyc", {31'd0, bus.Word_Valid}, 32'd0);

      // Burst with 3-cycle gaps, done two cycles after the last bit
      busyLow = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, gapWord[15-i], 1'b0);
         if (!bus.Busy) busyLow++;
         if (i < 15) begin
            for (int g = 0; g < 3; g++) begin
               applyStimulus(1'b0, 1'b1, 1'b0);
               if (!bus.Busy) busyLow++;
            end
         end
      end
      checkOutput("gap_no_early_valid", {31'd0, bus.Word_Valid}, 32'd0);
      idleCycles(1);
      if (!bus.Busy) busyLow++;
      checkOutput("gap_busy_low_cycles", busyLow, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("gap_valid", {31'd0, bus.Word_Valid}, 32'd1);
      checkOutput("gap_word",  {16'd0, bus.FCS_Word},   32'hC3A5);
      checkOutput("gap_busy_after", {31'd0, bus.Busy},  32'd0);
      idleCycles(1);
      checkOutput("gap_popped", {31'd0, bus.Word_Valid}, 32'd0);

      // Short burst: done after 10 bits
      sendBurst(16'hFFC0, 10, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("short_lenerr", {31'd0, bus.Len_Err},    32'd1);
      checkOutput("short_valid",  {31'd0, bus.Word_Valid}, 32'd0);
      checkOutput("short_busy",   {31'd0, bus.Busy},       32'd0);
      idleCycles(1);
      checkOutput("short_lenerr_pulse", {31'd0, bus.Len_Err},    32'd0);
      checkOutput("short_valid_after",  {31'd0, bus.Word_Valid}, 32'd0);

      // Long burst: 17 bits, done with the extra bit
      sendBurst(16'hFFFF, 17, 1'b1);
      checkOutput("long_lenerr", {31'd0, bus.Len_Err},    32'd1);
      checkOutput("long_valid",  {31'd0, bus.Word_Valid}, 32'd0);
      idleCycles(1);
      checkOutput("long_lenerr_pulse", {31'd0, bus.Len_Err},    32'd0);
      checkOutput("long_valid_after",  {31'd0, bus.Word_Valid}, 32'd0);

      // FIFO fill with consumer stalled, third word overruns
      bus.Word_Ready = 1'b0;
      sendBurst(16'hAAAA, 16, 1'b1);
      checkOutput("ovr_w1_valid", {31'd0, bus.Word_Valid}, 32'd1);
      checkOutput("ovr_w1_word",  {16'd0, bus.FCS_Word},   32'hAAAA);
      sendBurst(16'h5555, 16, 1'b1);
      checkOutput("ovr_w2_overrun", {31'd0, bus.Overrun}, 32'd0);
      checkOutput("ovr_w2_head",    {16'd0, bus.FCS_Word}, 32'hAAAA);
      sendBurst(16'h1234, 16, 1'b1);
      checkOutput("ovr_w3_overrun", {31'd0, bus.Overrun}, 32'd1);
      checkOutput("ovr_w3_head",    {16'd0, bus.FCS_Word}, 32'hAAAA);
      idleCycles(1);
      checkOutput("ovr_pulse",      {31'd0, bus.Overrun}, 32'd0);
      checkOutput("ovr_head_stable", {16'd0, bus.FCS_Word}, 32'hAAAA);
      bus.Word_Ready = 1'b1;
      idleCycles(1);
      checkOutput("ovr_pop2_valid", {31'd0, bus.Word_Valid}, 32'd1);
      checkOutput("ovr_pop2_word",  {16'd0, bus.FCS_Word},   32'h5555);
      idleCycles(1);
      checkOutput("ovr_empty", {31'd0, bus.Word_Valid}, 32'd0);

      // FIFO full, third word completes in the same cycle as a pop
      bus.Word_Ready = 1'b0;
      sendBurst(16'hAAAA, 16, 1'b1);
      sendBurst(16'h5555, 16, 1'b1);
      sendBurst(16'h1234, 15, 1'b0);
      bus.Word_Ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("pp_overrun", {31'd0, bus.Overrun}, 32'd0);
      checkOutput("pp_head2",   {16'd0, bus.FCS_Word}, 32'h5555);
      idleCycles(1);
      checkOutput("pp_head3_valid", {31'd0, bus.Word_Valid}, 32'd1);
      checkOutput("pp_head3",       {16'd0, bus.FCS_Word},   32'h1234);
      idleCycles(1);
      checkOutput("pp_empty", {31'd0, bus.Word_Valid}, 32'd0);

      // Asynchronous reset mid-burst with one word buffered
      bus.Word_Ready = 1'b0;
      sendBurst(16'h1111, 16, 1'b1);
      sendBurst(16'hF0F0, 8, 1'b0);
      checkOutput("ar_pre_busy",  {31'd0, bus.Busy},       32'd1);
      checkOutput("ar_pre_valid", {31'd0, bus.Word_Valid}, 32'd1);
      bus.Ser_Valid = 1'b0;
      bus.Ser_Done  = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("ar_valid",   {31'd0, bus.Word_Valid}, 32'd0);
      checkOutput("ar_word",    {16'd0, bus.FCS_Word},   32'd0);
      checkOutput("ar_busy",    {31'd0, bus.Busy},       32'd0);
      checkOutput("ar_lenerr",  {31'd0, bus.Len_Err},    32'd0);
      checkOutput("ar_overrun", {31'd0, bus.Overrun},    32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      sendBurst(16'hBEEF, 16, 1'b1);
      checkOutput("ar_beef_valid",  {31'd0, bus.Word_Valid}, 32'd1);
      checkOutput("ar_beef_word",   {16'd0, bus.FCS_Word},   32'hBEEF);
      checkOutput("ar_beef_lenerr", {31'd0, bus.Len_Err},    32'd0);
      bus.Word_Ready = 1'b1;
      idleCycles(1);
      checkOutput("ar_only_one_word", {31'd0, bus.Word_Valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
